// File: rtl/bp_me_pkg.sv
// Shared definitions for the memory-side command/response interface:
// message encodings and uncached-size helpers.
package bp_me_pkg;

  typedef enum logic [3:0] {
    e_mem_rd    = 4'd0,
    e_mem_uc_rd = 4'd1,
    e_mem_wb    = 4'd2,
    e_mem_uc_wr = 4'd3
  } bp_me_mem_msg_e;

  // Byte-offset width of the default 512-bit block.
  localparam int unsigned block_offset_width_gp = 6;

  function automatic int unsigned block_offset_width(input int unsigned block_width);
    return $clog2(block_width / 8);
  endfunction

  // Sizes above one dword saturate to a full dword.
  function automatic logic [7:0] size_to_byte_mask(input logic [2:0] size);
    case (size)
      3'd0:    return 8'h01;
      3'd1:    return 8'h03;
      3'd2:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [2:0] size_to_align_mask(input logic [2:0] size);
    case (size)
      3'd0:    return 3'd0;
      3'd1:    return 3'd1;
      3'd2:    return 3'd3;
      default: return 3'd7;
    endcase
  endfunction

endpackage

// File: rtl/bsg_mem_1rw_sync_mask_write_byte.sv
// Single-port synchronous block memory with per-byte write mask.
// The read register holds its value until the next read access.
module bsg_mem_1rw_sync_mask_write_byte
  #(parameter int unsigned els_p        = 256,
    parameter int unsigned data_width_p = 512,
    localparam int unsigned addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1,
    localparam int unsigned mask_width_lp = data_width_p / 8)
  (input  logic                     clk_i,
   input  logic                     v_i,
   input  logic                     w_i,
   input  logic [addr_width_lp-1:0] addr_i,
   input  logic [data_width_p-1:0]  data_i,
   input  logic [mask_width_lp-1:0] write_mask_i,
   output logic [data_width_p-1:0]  data_o);

  logic [data_width_p-1:0] mem_r [els_p];

  always_ff @(posedge clk_i) begin
    if (v_i) begin
      if (w_i) begin
        for (int unsigned i = 0; i < mask_width_lp; i++) begin
          if (write_mask_i[i]) mem_r[addr_i][8*i +: 8] <= data_i[8*i +: 8];
        end
      end else begin
        data_o <= mem_r[addr_i];
      end
    end
  end

endmodule

// File: rtl/bp_me_block_mem_responder.sv
// Deterministic memory responder: one command in flight, array access at
// acceptance, response presented after a fixed latency until yumi.
module bp_me_block_mem_responder
  import bp_me_pkg::*;
  #(parameter int unsigned paddr_width_p   = 40,
    parameter int unsigned block_width_p   = 512,
    parameter int unsigned els_p           = 256,
    parameter int unsigned latency_p       = 4,
    parameter int unsigned payload_width_p = 16,
    parameter logic [63:0] mem_offset_p    = 64'h8000_0000)
  (input  logic                       clk_i,
   input  logic                       reset_n_i,

   input  logic [3:0]                 mem_cmd_msg_type_i,
   input  logic [paddr_width_p-1:0]   mem_cmd_addr_i,
   input  logic [2:0]                 mem_cmd_size_i,
   input  logic [payload_width_p-1:0] mem_cmd_payload_i,
   input  logic [block_width_p-1:0]   mem_cmd_data_i,
   input  logic                       mem_cmd_v_i,
   output logic                       mem_cmd_ready_o,

   output logic [3:0]                 mem_resp_msg_type_o,
   output logic [paddr_width_p-1:0]   mem_resp_addr_o,
   output logic [2:0]                 mem_resp_size_o,
   output logic [payload_width_p-1:0] mem_resp_payload_o,
   output logic [block_width_p-1:0]   mem_resp_data_o,
   output logic                       mem_resp_v_o,
   input  logic                       mem_resp_yumi_i);

  localparam int unsigned off_w  = block_offset_width(block_width_p);
  localparam int unsigned idx_w  = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int unsigned rel_w  = off_w + idx_w;
  localparam int unsigned byte_w = block_width_p / 8;
  localparam int unsigned dw_w   = (off_w > 3) ? off_w - 3 : 1;
  localparam int unsigned cnt_w  = (latency_p > 1) ? $clog2(latency_p) : 1;

  typedef enum logic [1:0] {e_idle, e_wait, e_resp} state_e;

  state_e                 state_r, state_n;
  logic [cnt_w-1:0]       cnt_r, cnt_n;
  bp_me_mem_msg_e         cmd_type;
  logic                   accept;
  logic [rel_w-1:0]       rel_addr;
  logic [off_w-1:0]       boff, boff_al;
  logic [dw_w-1:0]        cmd_dw;
  logic [63:0]            uc_wdword;

  logic                   mem_v, mem_w;
  logic [byte_w-1:0]      mem_mask;
  logic [block_width_p-1:0] mem_wdata, mem_rdata;

  logic                   resp_rd_r, resp_uc_rd_r;
  logic [dw_w-1:0]        resp_dw_r;

  assign cmd_type        = bp_me_mem_msg_e'(mem_cmd_msg_type_i);
  assign mem_cmd_ready_o = reset_n_i & (state_r == e_idle);
  assign accept          = mem_cmd_v_i & mem_cmd_ready_o;

  // Only the low index+offset bits matter: the subtraction wraps modulo els_p.
  assign rel_addr  = mem_cmd_addr_i[rel_w-1:0] - mem_offset_p[rel_w-1:0];
  assign boff      = rel_addr[off_w-1:0];
  assign boff_al   = boff & ~off_w'(size_to_align_mask(mem_cmd_size_i));
  assign cmd_dw    = dw_w'(boff >> 3);
  assign uc_wdword = mem_cmd_data_i[63:0] << {boff_al[2:0], 3'b000};

  always_comb begin
    mem_v     = 1'b0;
    mem_w     = 1'b0;
    mem_mask  = '0;
    mem_wdata = mem_cmd_data_i;
    if (accept) begin
      case (cmd_type)
        e_mem_rd, e_mem_uc_rd: mem_v = 1'b1;
        e_mem_wb: begin
          mem_v    = 1'b1;
          mem_w    = 1'b1;
          mem_mask = '1;
        end
        e_mem_uc_wr: begin
          // Dword is pre-shifted to its lane, then replicated; the mask picks the bytes.
          mem_v     = 1'b1;
          mem_w     = 1'b1;
          mem_mask  = byte_w'(size_to_byte_mask(mem_cmd_size_i)) << boff_al;
          mem_wdata = {(block_width_p/64){uc_wdword}};
        end
        default: ;
      endcase
    end
  end

  bsg_mem_1rw_sync_mask_write_byte
    #(.els_p(els_p), .data_width_p(block_width_p))
  mem
    (.clk_i       (clk_i),
     .v_i         (mem_v),
     .w_i         (mem_w),
     .addr_i      (rel_addr[off_w +: idx_w]),
     .data_i      (mem_wdata),
     .write_mask_i(mem_mask),
     .data_o      (mem_rdata));

  always_comb begin
    state_n      = state_r;
    cnt_n        = cnt_r;
    mem_resp_v_o = 1'b0;
    case (state_r)
      e_idle: begin
        if (accept) begin
          cnt_n   = cnt_w'(latency_p - 1);
          state_n = (latency_p == 1) ? e_resp : e_wait;
        end
      end
      e_wait: begin
        cnt_n = cnt_r - cnt_w'(1);
        if (cnt_r <= cnt_w'(1)) begin
          cnt_n   = '0;
          state_n = e_resp;
        end
      end
      e_resp: begin
        mem_resp_v_o = 1'b1;
        if (mem_resp_yumi_i) state_n = e_idle;
      end
      default: state_n = e_idle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r             <= e_idle;
      cnt_r               <= '0;
      mem_resp_msg_type_o <= '0;
      mem_resp_addr_o     <= '0;
      mem_resp_size_o     <= '0;
      mem_resp_payload_o  <= '0;
      resp_rd_r           <= 1'b0;
      resp_uc_rd_r        <= 1'b0;
      resp_dw_r           <= '0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      if (accept) begin
        mem_resp_msg_type_o <= mem_cmd_msg_type_i;
        mem_resp_addr_o     <= mem_cmd_addr_i;
        mem_resp_size_o     <= mem_cmd_size_i;
        mem_resp_payload_o  <= mem_cmd_payload_i;
        resp_rd_r           <= (cmd_type == e_mem_rd);
        resp_uc_rd_r        <= (cmd_type == e_mem_uc_rd);
        resp_dw_r           <= cmd_dw;
      end
    end
  end

  // Read data lives in the memory's output register; only the type decides what is shown.
  always_comb begin
    mem_resp_data_o = '0;
    if (resp_rd_r)         mem_resp_data_o       = mem_rdata;
    else if (resp_uc_rd_r) mem_resp_data_o[63:0] = mem_rdata[64*resp_dw_r +: 64];
  end

endmodule

// File: tb/tb_bp_me_block_mem_responder.sv
// Directed bench for the block memory responder (latency 4 and latency 1 builds).
module tb_bp_me_block_mem_responder;

  localparam int unsigned PW  = 40;
  localparam int unsigned BW  = 512;
  localparam int unsigned LAT = 4;
  localparam int unsigned PLW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]     cmd_type    = '0;
  logic [PW-1:0]  cmd_addr    = '0;
  logic [2:0]     cmd_size    = '0;
  logic [PLW-1:0] cmd_payload = '0;
  logic [BW-1:0]  cmd_data    = '0;
  logic           cmd_v       = 1'b0;
  logic           resp_yumi   = 1'b0;
  logic           cmd_v1      = 1'b0;
  logic           resp_yumi1  = 1'b0;

  logic           cmd_ready, resp_v;
  logic [3:0]     resp_type;
  logic [PW-1:0]  resp_addr;
  logic [2:0]     resp_size;
  logic [PLW-1:0] resp_payload;
  logic [BW-1:0]  resp_data;

  logic           cmd_ready1, resp_v1;
  logic [3:0]     resp_type1;
  logic [PW-1:0]  resp_addr1;
  logic [2:0]     resp_size1;
  logic [PLW-1:0] resp_payload1;
  logic [BW-1:0]  resp_data1;

  int checks = 0;
  int errors = 0;

  bp_me_block_mem_responder #(
    .paddr_width_p(PW), .block_width_p(BW), .els_p(256), .latency_p(LAT),
    .payload_width_p(PLW), .mem_offset_p(64'h8000_0000)
  ) dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .mem_cmd_msg_type_i(cmd_type), .mem_cmd_addr_i(cmd_addr), .mem_cmd_size_i(cmd_size),
    .mem_cmd_payload_i(cmd_payload), .mem_cmd_data_i(cmd_data),
    .mem_cmd_v_i(cmd_v), .mem_cmd_ready_o(cmd_ready),
    .mem_resp_msg_type_o(resp_type), .mem_resp_addr_o(resp_addr), .mem_resp_size_o(resp_size),
    .mem_resp_payload_o(resp_payload), .mem_resp_data_o(resp_data),
    .mem_resp_v_o(resp_v), .mem_resp_yumi_i(resp_yumi)
  );

  bp_me_block_mem_responder #(
    .paddr_width_p(PW), .block_width_p(BW), .els_p(16), .latency_p(1),
    .payload_width_p(PLW), .mem_offset_p(64'h8000_0000)
  ) dut_l1 (
    .clk_i(clk), .reset_n_i(rst_n),
    .mem_cmd_msg_type_i(cmd_type), .mem_cmd_addr_i(cmd_addr), .mem_cmd_size_i(cmd_size),
    .mem_cmd_payload_i(cmd_payload), .mem_cmd_data_i(cmd_data),
    .mem_cmd_v_i(cmd_v1), .mem_cmd_ready_o(cmd_ready1),
    .mem_resp_msg_type_o(resp_type1), .mem_resp_addr_o(resp_addr1), .mem_resp_size_o(resp_size1),
    .mem_resp_payload_o(resp_payload1), .mem_resp_data_o(resp_data1),
    .mem_resp_v_o(resp_v1), .mem_resp_yumi_i(resp_yumi1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input string tag, input logic [3:0] t, input logic [PW-1:0] a,
                       input logic [2:0] s, input logic [PLW-1:0] p, input logic [BW-1:0] d);
    bit got;
    got         = 1'b0;
    cmd_type    = t;
    cmd_addr    = a;
    cmd_size    = s;
    cmd_payload = p;
    cmd_data    = d;
    cmd_v       = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      got = cmd_ready;
      tick();
    end
    cmd_v = 1'b0;
    chk($sformatf("%s_accept", tag), {511'b0, got}, 1);
  endtask

  // Called one cycle after acceptance; checks v_o timing, echo fields, data, and yumi.
  task automatic expect_resp(input string tag, input logic [3:0] t, input logic [PW-1:0] a,
                             input logic [2:0] s, input logic [PLW-1:0] p,
                             input logic [BW-1:0] d, input bit early_yumi);
    for (int i = 1; i < LAT; i++) begin
      chk($sformatf("%s_v_early%0d", tag, i), resp_v, 0);
      resp_yumi = early_yumi;
      tick();
    end
    resp_yumi = 1'b0;
    chk($sformatf("%s_v", tag), resp_v, 1);
    chk($sformatf("%s_type", tag), resp_type, t);
    chk($sformatf("%s_addr", tag), resp_addr, a);
    chk($sformatf("%s_size", tag), resp_size, s);
    chk($sformatf("%s_payload", tag), resp_payload, p);
    chk($sformatf("%s_data", tag), resp_data, d);
    resp_yumi = 1'b1;
    tick();
    resp_yumi = 1'b0;
    chk($sformatf("%s_v_after_yumi", tag), resp_v, 0);
    chk($sformatf("%s_ready_after_yumi", tag), cmd_ready, 1);
  endtask

  initial begin
    logic [BW-1:0] blk_a5, blk_3c, blk_wrap, blk_cafe;
    blk_a5   = {64{8'hA5}};
    blk_3c   = {64{8'h3C}};
    blk_wrap = {16{32'h1234_5678}};
    blk_cafe = {16{32'hCAFE_F00D}};

    // Reset state
    #3;
    chk("rst_ready", cmd_ready, 0);
    chk("rst_v", resp_v, 0);
    chk("rst_addr", resp_addr, 0);
    chk("rst_payload", resp_payload, 0);
    chk("rst_data", resp_data, 0);
    chk("rst_ready_l1", cmd_ready1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rel_v", resp_v, 0);
    chk("rel_ready", cmd_ready, 1);

    // Block writeback then block read in the same block
    issue("wb_a5", 4'd2, 40'h80_0000_0040, 3'd6, 16'h1111, blk_a5);
    expect_resp("wb_a5", 4'd2, 40'h80_0000_0040, 3'd6, 16'h1111, '0, 1'b0);
    issue("rd_a5", 4'd0, 40'h80_0000_0048, 3'd6, 16'h2222, '0);
    expect_resp("rd_a5", 4'd0, 40'h80_0000_0048, 3'd6, 16'h2222, blk_a5, 1'b1);

    // Uncached writes of several sizes over a zeroed block
    issue("wb_zero", 4'd2, 40'h80_0000_0000, 3'd6, 16'h0003, '0);
    expect_resp("wb_zero", 4'd2, 40'h80_0000_0000, 3'd6, 16'h0003, '0, 1'b0);
    issue("ucwr_s2", 4'd3, 40'h80_0000_0004, 3'd2, 16'h0004, {{448{1'b1}}, 64'h5555_5555_DEAD_BEEF});
    expect_resp("ucwr_s2", 4'd3, 40'h80_0000_0004, 3'd2, 16'h0004, '0, 1'b0);
    issue("ucrd_0", 4'd1, 40'h80_0000_0000, 3'd3, 16'h0005, '0);
    expect_resp("ucrd_0", 4'd1, 40'h80_0000_0000, 3'd3, 16'h0005, 512'hDEAD_BEEF_0000_0000, 1'b0);
    issue("ucwr_s0", 4'd3, 40'h80_0000_0003, 3'd0, 16'h0006, {8{64'hAAAA_AAAA_AAAA_AA77}});
    expect_resp("ucwr_s0", 4'd3, 40'h80_0000_0003, 3'd0, 16'h0006, '0, 1'b0);
    issue("ucwr_s7", 4'd3, 40'h80_0000_000C, 3'd7, 16'h0007, {8{64'h0123_4567_89AB_CDEF}});
    expect_resp("ucwr_s7", 4'd3, 40'h80_0000_000C, 3'd7, 16'h0007, '0, 1'b0);
    issue("ucrd_8", 4'd1, 40'h80_0000_000C, 3'd3, 16'h0008, '0);
    expect_resp("ucrd_8", 4'd1, 40'h80_0000_000C, 3'd3, 16'h0008, 512'h0123_4567_89AB_CDEF, 1'b0);
    issue("ucrd_4", 4'd1, 40'h80_0000_0004, 3'd2, 16'h0009, '0);
    expect_resp("ucrd_4", 4'd1, 40'h80_0000_0004, 3'd2, 16'h0009, 512'hDEAD_BEEF_7700_0000, 1'b0);

    // No-op encoding returns zero data
    issue("noop", 4'd9, 40'h80_0000_0040, 3'd3, 16'h000A, '1);
    expect_resp("noop", 4'd9, 40'h80_0000_0040, 3'd3, 16'h000A, '0, 1'b0);

    // Backpressure with a second command held on v_i
    issue("bp", 4'd0, 40'h80_0000_0040, 3'd6, 16'h3333, '0);
    for (int i = 1; i < LAT; i++) tick();
    cmd_type    = 4'd1;
    cmd_addr    = 40'h80_0000_0004;
    cmd_size    = 3'd3;
    cmd_payload = 16'h4444;
    cmd_v       = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("bp_v%0d", i), resp_v, 1);
      chk($sformatf("bp_ready%0d", i), cmd_ready, 0);
      chk($sformatf("bp_addr%0d", i), resp_addr, 40'h80_0000_0040);
      chk($sformatf("bp_payload%0d", i), resp_payload, 16'h3333);
      chk($sformatf("bp_data%0d", i), resp_data, blk_a5);
      tick();
    end
    resp_yumi = 1'b1;
    tick();
    resp_yumi = 1'b0;
    chk("bp_v_after_yumi", resp_v, 0);
    chk("bp_ready_after_yumi", cmd_ready, 1);
    tick();
    cmd_v = 1'b0;
    expect_resp("held", 4'd1, 40'h80_0000_0004, 3'd3, 16'h4444, 512'hDEAD_BEEF_7700_0000, 1'b0);

    // Index wraps modulo els_p
    issue("wrap_wb", 4'd2, 40'h80_0000_4000, 3'd6, 16'h0011, blk_wrap);
    expect_resp("wrap_wb", 4'd2, 40'h80_0000_4000, 3'd6, 16'h0011, '0, 1'b0);
    issue("wrap_rd", 4'd0, 40'h80_0000_0000, 3'd6, 16'h0012, '0);
    expect_resp("wrap_rd", 4'd0, 40'h80_0000_0000, 3'd6, 16'h0012, blk_wrap, 1'b0);

    // Reset while waiting: response dropped, write kept
    issue("rst_wb", 4'd2, 40'h80_0000_0080, 3'd6, 16'h0013, blk_3c);
    tick();
    chk("rstmid_v_wait", resp_v, 0);
    rst_n = 1'b0;
    #1;
    chk("rstmid_ready", cmd_ready, 0);
    chk("rstmid_v", resp_v, 0);
    chk("rstmid_payload", resp_payload, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("rstmid_no_resp%0d", i), resp_v, 0);
    end
    issue("rst_rd", 4'd0, 40'h80_0000_0080, 3'd6, 16'h0014, '0);
    expect_resp("rst_rd", 4'd0, 40'h80_0000_0080, 3'd6, 16'h0014, blk_3c, 1'b0);

    // Latency-1 build: back-to-back with yumi tied high
    cmd_type    = 4'd2;
    cmd_addr    = 40'h80_0000_0000;
    cmd_size    = 3'd6;
    cmd_payload = 16'h0006;
    cmd_data    = blk_cafe;
    cmd_v1      = 1'b1;
    resp_yumi1  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("l1_v%0d", i), resp_v1, (i % 2 == 0) ? 1 : 0);
    end
    cmd_type   = 4'd0;
    resp_yumi1 = 1'b0;
    tick();
    cmd_v1 = 1'b0;
    chk("l1_rd_v", resp_v1, 1);
    chk("l1_rd_type", resp_type1, 4'd0);
    chk("l1_rd_payload", resp_payload1, 16'h0006);
    chk("l1_rd_data", resp_data1, blk_cafe);
    resp_yumi1 = 1'b1;
    tick();
    resp_yumi1 = 1'b0;
    chk("l1_v_after_yumi", resp_v1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_me_block_mem_responder.md
# bp_me_block_mem_responder

Memory-side responder for the CCE/UCE memory command interface, the counterpart to the I$/UCE command initiator. Accepts one memory command at a time, services block reads, writebacks, uncached reads and uncached writes against an internal block-wide array, and returns one response per command after a fixed programmable latency. Used as a lightweight, deterministic replacement for the DRAM model in FE/ME unit benches.

## Interface
- paddr_width_p, 40, physical address width
- block_width_p, 512, cache block width in bits; power of two, at least 64
- els_p, 256, number of blocks stored; power of two
- latency_p, 4, cycles from command acceptance to response valid; minimum 1
- payload_width_p, 16, opaque command payload (LCE id, way, ...) echoed in the response
- mem_offset_p, 0x8000_0000, physical base address of the array
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- mem_cmd_msg_type_i  in  4  command type (bp_me_mem_msg_e)
- mem_cmd_addr_i  in  paddr_width_p  byte address
- mem_cmd_size_i  in  3  log2 of bytes for uncached ops
- mem_cmd_payload_i  in  payload_width_p  opaque, echoed
- mem_cmd_data_i  in  block_width_p  write data
- mem_cmd_v_i / mem_cmd_ready_o  in / out  1  valid/ready command handshake
- mem_resp_msg_type_o, mem_resp_addr_o, mem_resp_size_o, mem_resp_payload_o  out  4 / paddr_width_p / 3 / payload_width_p  echo of the accepted command
- mem_resp_data_o  out  block_width_p  read data
- mem_resp_v_o / mem_resp_yumi_i  out / in  1  valid/yumi response handshake

## Operation
- Message types: e_mem_rd=0 (block read), e_mem_uc_rd=1, e_mem_wb=2 (block write), e_mem_uc_wr=3; other encodings are no-ops.
- Index = ((addr − mem_offset_p) >> log2(block_width_p/8)) mod els_p; out-of-range addresses wrap, never error.
- e_mem_rd: returns the whole block; the response addr echoes the command addr unmodified.
- e_mem_uc_rd: returns the naturally aligned 64-bit dword containing addr in data[63:0], upper bits zero.
- e_mem_wb: writes the full block.
- e_mem_uc_wr: writes the low 2^size bytes of data[63:0] at addr aligned down to 2^size; size > 3 is treated as 3; other bytes are unchanged.
- Writes and no-ops return data 0.
- States:
  - IDLE: ready_o=1. On v_i&ready_o, perform the array access, capture the echo fields and read data into the response register, load the counter with latency_p−1, go to WAIT (or to RESP if latency_p=1).
  - WAIT: decrement; at 0 go to RESP.
  - RESP: v_o=1; on yumi_i go to IDLE.
- Ordering: the array is written on the acceptance edge, so a read accepted later always sees the earlier write.

## Timing
- Reset (reset_n_i=0, asynchronous): state=IDLE, counter=0, mem_resp_v_o=0, mem_cmd_ready_o=0 while reset is asserted, response fields 0. Array contents are not reset.
- ready_o rises in the first cycle after reset release.
- Command accepted in cycle t: mem_resp_v_o is first high in cycle t+latency_p. Response fields stay stable until the yumi.
- mem_resp_yumi_i is legal only while v_o=1; yumi while v_o=0 is ignored.
- ready_o is high only in IDLE, so the next command is accepted no earlier than the cycle after the yumi. Peak throughput is one command per latency_p+1 cycles.
- A command presented during WAIT or RESP is held off with ready_o=0 and is not dropped.
- Reset mid-operation: the pending response is discarded and no response is issued; array writes already committed remain.

## Structure
- The shared package bp_me_pkg holds:
  - the bp_me_mem_msg_e enum;
  - the size-to-byte-mask helper function;
  - the block offset width constant.
- Storage is one sub-module, bsg_mem_1rw_sync_mask_write_byte (els_p × block_width_p), with a single read/write port used at acceptance. The rest is the FSM, the latency counter and the response register.

## Test plan
- Reset release: v_o=0 and ready_o=1 in cycle 1. A wb of 0xA5 repeated to 0x8000_0040, then an rd of 0x8000_0048 -> response data all 0xA5, addr 0x8000_0048, payload echoed, v_o exactly 4 cycles after acceptance.
- uc_wr size=2, data 0xDEADBEEF to 0x8000_0004 over a zeroed block, then uc_rd 0x8000_0000 -> data[63:0]=0xDEADBEEF_00000000.
- Backpressure: hold yumi_i=0 for 10 cycles -> v_o and all fields stable throughout; a second command held on v_i is not accepted until the cycle after the yumi.
- Wrap: wb to mem_offset_p + els_p×64, then rd of mem_offset_p -> returns the same block.
- latency_p=1 build: back-to-back commands with yumi tied high -> one response every 2 cycles.
- Assert reset_n_i during WAIT -> no response after release; data written by the interrupted command is readable afterwards.
